areg_file: RTL and testbench
============================

Name: areg_file

Overview:
- Parametrised accumulate/overwrite register file with a masked write path.
- NRD combinational read ports, with forwarding from a one-deep write pipeline stage.
- Configurable lower-to-upper mirror region and a sequenced whole-file clear.
- Sits between the decode/execute stage and the accumulator consumers of the sequencer datapath; successor of the fixed 16-entry single-read accumulate file.

Parameters:
- WIDTH, 16, bits per entry.
- DEPTH, 16, number of entries; power of two, ≥ 2. AW = $clog2(DEPTH).
- NRD, 2, number of read ports, ≥ 1.
- MIRROR_N, 8, entries [0, MIRROR_N) are mirrored; 0 disables mirroring.
- MIRROR_OFS, 8, mirror target = addr + MIRROR_OFS. Must satisfy MIRROR_N ≤ MIRROR_OFS and MIRROR_N + MIRROR_OFS ≤ DEPTH; otherwise elaboration error.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NRD*AW  packed read addresses; port k = slice k
- rd_data  out  NRD*WIDTH  packed read data
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write operand
- wr_mode  in  1  1 = overwrite, 0 = accumulate (old + wr_data)
- wr_mask  in  WIDTH  1 = take new bit, 0 = keep old bit
- clr_req  in  1  request whole-file clear
- busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse on the last clear write
- sat  out  1  sticky saturation flag (see Optional Feature)

Behaviour:
- Reset (async):
  - All entries = 0; S1 valid = 0; FSM = IDLE; clear counter = 0.
  - busy = 0, clr_done = 0, sat = 0.
  - wr_ready = 1 once rst deasserts.
- Write pipeline, S1 stage:
  - An accepted request at edge N registers {addr, data, mode, mask} into S1.
  - During cycle N+1, S1 computes nval = mode ? data : old + data, where old = rfile[addr].
  - Commit value = (old & ~mask) | (nval & mask), written at edge N+1.
  - Write latency: 2 edges from acceptance to storage.
  - The file is read at commit time, so back-to-back writes to the same address need no stall.
- Mirror: if the S1 address < MIRROR_N, the same commit value is also written to addr + MIRROR_OFS at the same edge. Direct writes to a mirror target are ordinary writes and do not propagate back.
- Arithmetic: accumulate is unsigned, modulo 2^WIDTH (wrap) unless AREG_SAT_EN is defined.
- Read ports:
  - Combinational. rd_data[k] = rfile[rd_addr[k]].
  - Exception: when S1 is valid and rd_addr[k] equals the S1 address or its mirror target, rd_data[k] = the S1 commit value (forwarding).
  - Ports are independent; identical addresses on several ports are legal.
- FSM, IDLE → CLEAR:
  - Transition when in IDLE and clr_req = 1.
  - wr_ready = (state == IDLE) && !clr_req, so no write is accepted in the request cycle.
  - A valid S1 still commits at the edge that enters CLEAR.
- FSM, CLEAR:
  - busy = 1, wr_ready = 0.
  - Entry cnt is zeroed at each edge; cnt increments 0 to DEPTH-1. Clear lasts DEPTH cycles.
  - clr_done = 1 during the cycle with cnt == DEPTH-1.
  - Next state is IDLE; cnt returns to 0.
  - clr_req is ignored while in CLEAR.
  - Reads during CLEAR return current (partially cleared) contents; there is no forwarding, since S1 is empty.
- Simultaneous wr_valid and clr_req in IDLE: the clear wins and the write is not accepted (wr_ready = 0).
- Reset mid-clear or mid-S1: immediate return to the reset state; the in-flight write is lost.

Optional Feature:
- AREG_SAT_EN defined:
  - Accumulate saturates unsigned. If old + data overflows WIDTH bits, nval = all-ones.
  - sat is set on any committed saturating accumulate (before masking) and is cleared only by rst or a completed clear.
- Undefined: accumulate wraps; sat is tied to 0.

Decomposition:
- Package areg_pkg:
  - word_t typedef (logic [WIDTH-1:0] via parameterised default).
  - Mode encoding constants MODE_ACC = 0, MODE_OVW = 1.
  - FSM enum {IDLE, CLEAR}.
  - Function masked(old, nval, mask).
- Sub-module areg_wstage holds the S1 registers plus nval/commit/saturation computation. It outputs {valid, addr, mirror_hit, mirror_addr, commit_val, sat_evt} to the storage and forwarding logic in areg_file.

Test Plan (WIDTH=16, DEPTH=16):
- Reset, then overwrite 0x1234 to addr 3 with mask 0xFFFF → rd_data[0] at addr 3 = 0x1234 while S1 is valid (forwarded) and after commit; addr 11 (mirror) = 0x1234.
- Accumulate 0x0001 to addr 5 in three consecutive cycles from 0x00FF → 0x0102; addr 13 = 0x0102; a read of addr 5 shows each intermediate value one cycle after each accept.
- Mask 0x00F0, overwrite 0xABCD to addr 2 holding 0x1111 → 0x11C1.
- Accumulate 0x0002 to addr 9 holding 0xFFFF → 0x0001 and sat = 0 without the macro; 0xFFFF and sat = 1 with AREG_SAT_EN.
- clr_req and wr_valid in the same cycle → write dropped; busy high 16 cycles; clr_done pulses once at cnt 15; all entries read 0; wr_ready back to 1.
- Assert rst at clear cnt 7 with entries preloaded → all entries 0, busy = 0 immediately, no clr_done pulse.

Source files
------------

// File: rtl/areg_pkg.sv
// Shared types, mode encodings and the masked-merge helper for the accumulate register file.
// AREG_SAT_EN (in areg_wstage) switches accumulate from wrapping to saturating arithmetic.
package areg_pkg;

  localparam int AREG_WIDTH = 16;
  // Upper bound on WIDTH: masked() works on this many bits and callers size-cast
  localparam int AREG_MW = 128;

  typedef logic [AREG_WIDTH-1:0] word_t;

  localparam logic MODE_ACC = 1'b0;
  localparam logic MODE_OVW = 1'b1;

  typedef enum logic {IDLE, CLEAR} state_t;

  function automatic logic [AREG_MW-1:0] masked(input logic [AREG_MW-1:0] old,
                                                input logic [AREG_MW-1:0] nval,
                                                input logic [AREG_MW-1:0] mask);
    return (old & ~mask) | (nval & mask);
  endfunction

endpackage

// File: rtl/areg_wstage.sv
// One-deep write pipeline stage: holds an accepted request and builds its commit value.
// With AREG_SAT_EN defined, accumulate saturates and raises sat_evt on overflow.
module areg_wstage
  import areg_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int MIRROR_N   = 8,
  parameter int MIRROR_OFS = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [AW-1:0]    in_addr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_mask,
  input  logic [WIDTH-1:0] old,
  output logic             valid,
  output logic [AW-1:0]    addr,
  output logic             mirror_hit,
  output logic [AW-1:0]    mirror_addr,
  output logic [WIDTH-1:0] commit_val,
  output logic             sat_evt
);

  logic [WIDTH-1:0] s1_data;
  logic [WIDTH-1:0] s1_mask;
  logic             s1_mode;
  logic [WIDTH-1:0] nval;
  logic             acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      addr    <= '0;
      s1_data <= '0;
      s1_mask <= '0;
      s1_mode <= MODE_ACC;
    end else begin
      valid <= in_valid;
      if (in_valid) begin
        addr    <= in_addr;
        s1_data <= in_data;
        s1_mask <= in_mask;
        s1_mode <= in_mode;
      end
    end
  end

  assign acc = (s1_mode == MODE_ACC);

`ifdef AREG_SAT_EN
  logic [WIDTH:0] sum;

  // The carry out of the widened sum is the overflow condition
  always_comb begin
    sum     = {1'b0, old} + {1'b0, s1_data};
    nval    = acc ? (sum[WIDTH] ? '1 : sum[WIDTH-1:0]) : s1_data;
    sat_evt = valid && acc && sum[WIDTH];
  end
`else
  logic [WIDTH-1:0] sum;

  always_comb begin
    sum     = old + s1_data;
    nval    = acc ? sum : s1_data;
    sat_evt = 1'b0;
  end
`endif

  always_comb begin
    commit_val  = WIDTH'(masked(AREG_MW'(old), AREG_MW'(nval), AREG_MW'(s1_mask)));
    mirror_hit  = valid && (addr < AW'(MIRROR_N));
    mirror_addr = addr + AW'(MIRROR_OFS);
  end

endmodule

// File: rtl/areg_file.sv
// Accumulate/overwrite register file with masked writes, forwarding read ports,
// a lower-to-upper mirror region and a sequenced clear. Optional macro: AREG_SAT_EN.
module areg_file
  import areg_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int NRD        = 2,
  parameter int MIRROR_N   = 8,
  parameter int MIRROR_OFS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRD*$clog2(DEPTH)-1:0] rd_addr,
  output logic [NRD*WIDTH-1:0]     rd_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_mode,
  input  logic [WIDTH-1:0]         wr_mask,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done,
  output logic                     sat
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_LAST = AW'(DEPTH - 2);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("areg_file: DEPTH must be a power of two and at least 2");
  end
  if (NRD < 1) begin : g_bad_nrd
    $error("areg_file: NRD must be at least 1");
  end
  if (MIRROR_N > MIRROR_OFS || MIRROR_N + MIRROR_OFS > DEPTH) begin : g_bad_mirror
    $error("areg_file: mirror region must not overlap itself or run past DEPTH");
  end

  logic [WIDTH-1:0] rfile [DEPTH];
  state_t           state;
  logic [AW-1:0]    cnt;

  logic             s1_valid;
  logic [AW-1:0]    s1_addr;
  logic             mirror_hit;
  logic [AW-1:0]    mirror_addr;
  logic [WIDTH-1:0] commit_val;
  logic             sat_evt;
  logic             accept;

  // A pending clear request blocks acceptance in the same cycle, so the clear wins
  assign wr_ready = !rst && (state == IDLE) && !clr_req;
  assign accept   = wr_valid && wr_ready;

  areg_wstage #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .MIRROR_N  (MIRROR_N),
    .MIRROR_OFS(MIRROR_OFS),
    .AW        (AW)
  ) u_wstage (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (accept),
    .in_addr    (wr_addr),
    .in_data    (wr_data),
    .in_mode    (wr_mode),
    .in_mask    (wr_mask),
    .old        (rfile[s1_addr]),
    .valid      (s1_valid),
    .addr       (s1_addr),
    .mirror_hit (mirror_hit),
    .mirror_addr(mirror_addr),
    .commit_val (commit_val),
    .sat_evt    (sat_evt)
  );

  // S1 is always empty while clearing, so the two write sources never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rfile[i] <= '0;
    end else if (state == CLEAR) begin
      rfile[cnt] <= '0;
    end else if (s1_valid) begin
      rfile[s1_addr] <= commit_val;
      if (mirror_hit) rfile[mirror_addr] <= commit_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      sat      <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      if (sat_evt) sat <= 1'b1;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            sat   <= 1'b0;
          end else begin
            cnt      <= cnt + 1'b1;
            clr_done <= (cnt == PRE_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          fwd;
    assign ra  = rd_addr[k*AW +: AW];
    assign fwd = s1_valid && ((ra == s1_addr) || (mirror_hit && (ra == mirror_addr)));
    assign rd_data[k*WIDTH +: WIDTH] = fwd ? commit_val : rfile[ra];
  end

endmodule

// File: tb/tb_areg_file.sv
// Randomised and directed bench for areg_file with a queue-based scoreboard and a
// sequential reference model; honours AREG_SAT_EN like the design.
module tb_areg_file;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int NRD   = 2;

  localparam int SEL_RD0 = 0;
  localparam int SEL_RD1 = 1;
  localparam int SEL_RDY = 2;
  localparam int SEL_BSY = 3;
  localparam int SEL_DON = 4;
  localparam int SEL_SAT = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NRD*4-1:0] rd_addr = '0;
  logic [NRD*WIDTH-1:0] rd_data;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [3:0]       wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_mode = 1'b0;
  logic [WIDTH-1:0] wr_mask = '0;
  logic             clr_req = 1'b0;
  logic             busy;
  logic             clr_done;
  logic             sat;

  areg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .MIRROR_N(8), .MIRROR_OFS(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_mode (wr_mode),
    .wr_mask (wr_mask),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_done(clr_done),
    .sat     (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model: the file as seen by readers, with every accepted write applied at once
  logic [15:0] mem [DEPTH];
  bit          busy_m;
  int          cnt_m;
  bit          sat_m;
  bit          sat_pend;

  function automatic void push(input int sel, input logic [15:0] exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sbq.push_back(e);
  endfunction

  function automatic void resetModel();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0;
    busy_m   = 0;
    cnt_m    = 0;
    sat_m    = 0;
    sat_pend = 0;
  endfunction

  function automatic void modelEdge();
    sat_m    = sat_m | sat_pend;
    sat_pend = 0;
    if (busy_m) begin
      mem[cnt_m] = 16'h0;
      if (cnt_m == DEPTH - 1) begin
        busy_m = 0;
        cnt_m  = 0;
        sat_m  = 0;
      end else begin
        cnt_m++;
      end
    end else if (clr_req) begin
      busy_m = 1;
      cnt_m  = 0;
    end else if (wr_valid) begin
      int          a;
      int          total;
      logic [15:0] old;
      logic [15:0] nv;
      logic [15:0] res;
      a   = int'(wr_addr);
      old = mem[a];
      if (wr_mode) begin
        nv = wr_data;
      end else begin
        total = int'(old) + int'(wr_data);
`ifdef AREG_SAT_EN
        if (total > 65535) begin
          nv       = 16'hFFFF;
          sat_pend = 1;
        end else begin
          nv = total[15:0];
        end
`else
        nv = total[15:0];
`endif
      end
      res    = (old & ~wr_mask) | (nv & wr_mask);
      mem[a] = res;
      if (a < 8) mem[a + 8] = res;
    end
  endfunction

  task automatic checkOutput();
    push(SEL_RD0, mem[int'(rd_addr[3:0])], "rd0");
    push(SEL_RD1, mem[int'(rd_addr[7:4])], "rd1");
    push(SEL_RDY, {15'h0, !busy_m && !clr_req}, "wr_ready");
    push(SEL_BSY, {15'h0, busy_m}, "busy");
    push(SEL_DON, {15'h0, busy_m && (cnt_m == DEPTH - 1)}, "clr_done");
    push(SEL_SAT, {15'h0, sat_m}, "sat");
  endtask

  task automatic applyStimulus(input logic wv, input logic [3:0] wa, input logic [15:0] wd,
                               input logic wm, input logic [15:0] wmask, input logic clr,
                               input logic [3:0] ra0, input logic [3:0] ra1);
    wr_valid = wv;
    wr_addr  = wa;
    wr_data  = wd;
    wr_mode  = wm;
    wr_mask  = wmask;
    clr_req  = clr;
    rd_addr  = {ra1, ra0};
    checkOutput();
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input logic [3:0] ra0, input logic [3:0] ra1);
    rst      = 1'b1;
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    rd_addr  = {ra1, ra0};
    resetModel();
    #2;
    push(SEL_RD0, 16'h0, "reset_rd0");
    push(SEL_RD1, 16'h0, "reset_rd1");
    push(SEL_BSY, 16'h0, "reset_busy");
    push(SEL_DON, 16'h0, "reset_clr_done");
    push(SEL_SAT, 16'h0, "reset_sat");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: drains everything queued for the current cycle on the falling edge
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        case (e.sel)
          SEL_RD0: act = rd_data[15:0];
          SEL_RD1: act = rd_data[31:16];
          SEL_RDY: act = {15'h0, wr_ready};
          SEL_BSY: act = {15'h0, busy};
          SEL_DON: act = {15'h0, clr_done};
          default: act = {15'h0, sat};
        endcase
        checks++;
        if (act !== e.exp) begin
          fails++;
          $display("[TB] FAIL %s at %0t: got %h expected %h", e.name, $time, act, e.exp);
        end
      end
    end
  end

  initial begin
    doReset(4'd3, 4'd11);

    // Overwrite with full mask, forwarded then committed, plus mirror
    applyStimulus(1, 4'd3, 16'h1234, 1, 16'hFFFF, 0, 4'd3, 4'd11); tick();
    applyStimulus(0, 4'd0, 16'h0, 0, 16'h0, 0, 4'd3, 4'd11);
    push(SEL_RD0, 16'h1234, "fwd_addr3");
    push(SEL_RD1, 16'h1234, "fwd_mirror11");
    tick();
    applyStimulus(0, 4'd0, 16'h0, 0, 16'h0, 0, 4'd3, 4'd11);
    push(SEL_RD0, 16'h1234, "commit_addr3");
    push(SEL_RD1, 16'h1234, "commit_mirror11");
    tick();

    // Back-to-back accumulates to the same address
    applyStimulus(1, 4'd5, 16'h00FF, 1, 16'hFFFF, 0, 4'd5, 4'd13); tick();
    applyStimulus(1, 4'd5, 16'h0001, 0, 16'hFFFF, 0, 4'd5, 4'd13);
    push(SEL_RD0, 16'h00FF, "acc_pre");
    tick();
    applyStimulus(1, 4'd5, 16'h0001, 0, 16'hFFFF, 0, 4'd5, 4'd13);
    push(SEL_RD0, 16'h0100, "acc_step1");
    tick();
    applyStimulus(1, 4'd5, 16'h0001, 0, 16'hFFFF, 0, 4'd5, 4'd13);
    push(SEL_RD0, 16'h0101, "acc_step2");
    tick();
    applyStimulus(0, 4'd0, 16'h0, 0, 16'h0, 0, 4'd5, 4'd13);
    push(SEL_RD0, 16'h0102, "acc_final5");
    push(SEL_RD1, 16'h0102, "acc_mirror13");
    tick();

    // Partial mask overwrite
    applyStimulus(1, 4'd2, 16'h1111, 1, 16'hFFFF, 0, 4'd2, 4'd10); tick();
    applyStimulus(1, 4'd2, 16'hABCD, 1, 16'h00F0, 0, 4'd2, 4'd10); tick();
    applyStimulus(0, 4'd0, 16'h0, 0, 16'h0, 0, 4'd2, 4'd10);
    push(SEL_RD0, 16'h11C1, "mask_addr2");
    push(SEL_RD1, 16'h11C1, "mask_mirror10");
    tick();

    // Overflowing accumulate
    applyStimulus(1, 4'd9, 16'hFFFF, 1, 16'hFFFF, 0, 4'd9, 4'd1); tick();
    applyStimulus(1, 4'd9, 16'h0002, 0, 16'hFFFF, 0, 4'd9, 4'd1); tick();
    applyStimulus(0, 4'd0, 16'h0, 0, 16'h0, 0, 4'd9, 4'd1);
`ifdef AREG_SAT_EN
    push(SEL_RD0, 16'hFFFF, "ovf_value");
`else
    push(SEL_RD0, 16'h0001, "ovf_value");
`endif
    tick();
    applyStimulus(0, 4'd0, 16'h0, 0, 16'h0, 0, 4'd9, 4'd1);
`ifdef AREG_SAT_EN
    push(SEL_SAT, 16'h1, "ovf_sat");
`else
    push(SEL_SAT, 16'h0, "ovf_sat");
`endif
    tick();

    // Clear racing a write: the write is dropped
    applyStimulus(1, 4'd4, 16'h5555, 1, 16'hFFFF, 1, 4'd4, 4'd12);
    push(SEL_RDY, 16'h0, "clr_blocks_write");
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 4'd0, 16'h0, 0, 16'h0, (i >= 3 && i < 6), 4'(i), 4'(15 - i));
      push(SEL_BSY, 16'h1, "clear_busy");
      push(SEL_DON, {15'h0, i == DEPTH - 1}, "clear_done_pulse");
      tick();
    end
    for (int j = 0; j < DEPTH / 2; j++) begin
      applyStimulus(0, 4'd0, 16'h0, 0, 16'h0, 0, 4'(2 * j), 4'(2 * j + 1));
      push(SEL_RD0, 16'h0, "cleared_even");
      push(SEL_RD1, 16'h0, "cleared_odd");
      push(SEL_RDY, 16'h1, "ready_after_clear");
      tick();
    end

    // Reset in the middle of a clear
    applyStimulus(1, 4'd9, 16'h0909, 1, 16'hFFFF, 0, 4'd9, 4'd12); tick();
    applyStimulus(1, 4'd12, 16'h0C0C, 1, 16'hFFFF, 0, 4'd9, 4'd12); tick();
    applyStimulus(0, 4'd0, 16'h0, 0, 16'h0, 1, 4'd9, 4'd12); tick();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 4'd0, 16'h0, 0, 16'h0, 0, 4'd9, 4'd12); tick();
    end
    doReset(4'd9, 4'd12);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 4'd0, 16'h0, 0, 16'h0, 0, 4'd9, 4'd12);
      push(SEL_DON, 16'h0, "no_done_after_reset");
      tick();
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [15:0] d;
      logic [15:0] m;
      d = ($urandom_range(0, 3) == 0) ? 16'(16'hFF00 | $urandom_range(0, 255)) : 16'($urandom);
      m = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'hFFFF;
      applyStimulus($urandom_range(0, 3) != 0, 4'($urandom), d, 1'($urandom), m,
                    $urandom_range(0, 59) == 0, 4'($urandom), 4'($urandom));
      tick();
    end

    wr_valid = 1'b0;
    clr_req  = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
